// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two requesters.
// Commands are registered onto the ALU inputs, then the result is captured and returned on a tagged response channel.
module alu_rr_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_r,
    output logic              rsp_zf,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_r_q, rsp_r_d;
    logic              rsp_zf_q, rsp_zf_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic              grant0, grant1;
    logic              sel_id;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              sel_illegal;

    // On a tie the requester that did not win last time is served.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);
    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    assign sel_id      = grant1;
    assign sel_op      = sel_id ? req1_op : req0_op;
    assign sel_a       = sel_id ? req1_a : req0_a;
    assign sel_b       = sel_id ? req1_b : req0_b;
    assign sel_illegal = sel_op[2] & sel_op[1];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        err_d        = err_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_r_d      = rsp_r_q;
        rsp_zf_d     = rsp_zf_q;
        rsp_err_d    = rsp_err_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    id_d         = sel_id;
                    last_grant_d = sel_id;
                    err_d        = sel_illegal;
                    // Illegal opcodes leave the ALU inputs untouched.
                    if (!sel_illegal) begin
                        alu_a_d   = sel_a;
                        alu_b_d   = sel_b;
                        alu_sel_d = {1'b0, sel_op};
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                if (err_q) begin
                    rsp_r_d   = '0;
                    rsp_zf_d  = 1'b1;
                    rsp_err_d = 1'b1;
                end else begin
                    rsp_r_d   = alu_r;
                    rsp_zf_d  = alu_zf;
                    rsp_err_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_id_q) cnt1_d = cnt1_q + CNT_W'(1);
                    else          cnt0_d = cnt0_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_r_q      <= '0;
            rsp_zf_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            err_q        <= err_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_r_q      <= rsp_r_d;
            rsp_zf_q     <= rsp_zf_d;
            rsp_err_q    <= rsp_err_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_zf    = rsp_zf_q;
    assign rsp_err   = rsp_err_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level reference model feeding a response scoreboard.
module tb_alu_rr_arbiter;

    localparam int TB_CNT_W = 4;

    typedef struct {
        logic        id;
        logic [31:0] r;
        logic        zf;
        logic        err;
    } rsp_t;

    logic                clk;
    logic                rst;
    logic                req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]         req0_a, req0_b, req1_a, req1_b;
    logic [2:0]          req0_op, req1_op;
    logic [31:0]         alu_a, alu_b, alu_r;
    logic [3:0]          alu_sel;
    logic                alu_zf;
    logic                rsp_valid, rsp_ready, rsp_id, rsp_zf, rsp_err;
    logic [31:0]         rsp_r;
    logic [TB_CNT_W-1:0] cnt0, cnt1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    rsp_t exp_q[$];

    alu_rr_arbiter #(.DATA_W(32), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_r(alu_r), .alu_zf(alu_zf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external ALU instance.
    always_comb begin
        case (alu_sel)
            4'd0:    alu_r = alu_a & alu_b;
            4'd1:    alu_r = alu_a | alu_b;
            4'd2:    alu_r = alu_a + alu_b;
            4'd3:    alu_r = alu_a - alu_b;
            4'd4:    alu_r = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'd5:    alu_r = ~(alu_a | alu_b);
            default: alu_r = 32'd0;
        endcase
    end
    assign alu_zf = (alu_r == 32'd0);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic rsp_t refOp(input logic id, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        rsp_t t;
        t.id  = id;
        t.err = 1'b0;
        case (op)
            3'd0:    t.r = a & b;
            3'd1:    t.r = a | b;
            3'd2:    t.r = a + b;
            3'd3:    t.r = a - b;
            3'd4:    t.r = (a < b) ? 32'd1 : 32'd0;
            3'd5:    t.r = ~(a | b);
            default: begin
                t.r   = 32'd0;
                t.err = 1'b1;
            end
        endcase
        t.zf = (t.r == 32'd0);
        return t;
    endfunction

    // Transaction-level model: one op in flight, response two cycles after accept,
    // busy until the response handshake, ties alternate starting with requester 0.
    logic        model_ok = 1'b0;
    logic        busy, last_m, cur_id;
    logic        m_g0, m_g1, m_rspv;
    int          cnt0m, cnt1m, acc_cyc;
    logic [31:0] exp_a, exp_b;
    logic [3:0]  exp_sel;
    rsp_t        m_new;

    always @(negedge clk) begin
        m_g0   = !busy && req0_valid && (!req1_valid || last_m);
        m_g1   = !busy && req1_valid && (!req0_valid || !last_m);
        m_rspv = busy && (cyc >= acc_cyc + 2);
        if (model_ok) begin
            checkOutput("req0_ready", 64'(req0_ready), 64'(m_g0));
            checkOutput("req1_ready", 64'(req1_ready), 64'(m_g1));
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
            checkOutput("cnt0", 64'(cnt0), 64'(cnt0m % (1 << TB_CNT_W)));
            checkOutput("cnt1", 64'(cnt1), 64'(cnt1m % (1 << TB_CNT_W)));
            checkOutput("alu_a", 64'(alu_a), 64'(exp_a));
            checkOutput("alu_b", 64'(alu_b), 64'(exp_b));
            checkOutput("alu_sel", 64'(alu_sel), 64'(exp_sel));
        end
        if (rst) begin
            busy     = 1'b0;
            last_m   = 1'b1;
            cur_id   = 1'b0;
            cnt0m    = 0;
            cnt1m    = 0;
            acc_cyc  = 0;
            exp_a    = 32'd0;
            exp_b    = 32'd0;
            exp_sel  = 4'd0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (busy) begin
                if (m_rspv && rsp_ready) begin
                    if (cur_id) cnt1m++;
                    else        cnt0m++;
                    busy = 1'b0;
                end
            end else if (m_g0 || m_g1) begin
                if (m_g1) m_new = refOp(1'b1, req1_op, req1_a, req1_b);
                else      m_new = refOp(1'b0, req0_op, req0_a, req0_b);
                exp_q.push_back(m_new);
                if (!m_new.err) begin
                    exp_a   = m_g1 ? req1_a : req0_a;
                    exp_b   = m_g1 ? req1_b : req0_b;
                    exp_sel = {1'b0, (m_g1 ? req1_op : req0_op)};
                end
                busy    = 1'b1;
                cur_id  = m_g1;
                last_m  = m_g1;
                acc_cyc = cyc;
            end
        end
    end

    // Response monitor: each new response pops the next expected entry and is
    // compared every cycle it stays valid.
    logic mon_ok = 1'b0;
    logic prev_valid = 1'b0;
    logic have_cur = 1'b0;
    logic just_rst = 1'b0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;
    int   rd_idx = 0;
    rsp_t cur;

    always @(negedge clk) begin
        if (mon_ok) begin
            if (rsp_valid === 1'b1 && !prev_valid) begin
                if (rd_idx < exp_q.size()) begin
                    cur      = exp_q[rd_idx];
                    rd_idx   = rd_idx + 1;
                    have_cur = 1'b1;
                end else begin
                    checkOutput("unexpected_rsp", 64'(1), 64'(0));
                    have_cur = 1'b0;
                end
            end
            if (rsp_valid === 1'b1 && have_cur) begin
                checkOutput("rsp_id", 64'(rsp_id), 64'(cur.id));
                checkOutput("rsp_r", 64'(rsp_r), 64'(cur.r));
                checkOutput("rsp_zf", 64'(rsp_zf), 64'(cur.zf));
                checkOutput("rsp_err", 64'(rsp_err), 64'(cur.err));
            end
            if (just_rst && !rst) begin
                checkOutput("reset_rsp_fields", 64'({rsp_id, rsp_zf, rsp_err, rsp_r}), 64'(0));
                just_rst = 1'b0;
            end
            if (end_req && !end_done) begin
                checkOutput("drain", 64'(rd_idx), 64'(exp_q.size()));
                end_done = 1'b1;
            end
        end
        prev_valid = mon_ok ? (rsp_valid === 1'b1) : 1'b0;
        if (rst) begin
            mon_ok   = 1'b1;
            rd_idx   = exp_q.size();
            have_cur = 1'b0;
            just_rst = 1'b1;
        end
    end

    task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [31:0] a0,
                                 input logic [31:0] b0, input logic v1, input logic [2:0] op1,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitGrant1(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req1_ready) break;
        end
        @(posedge clk);
        #1;
    endtask

    logic hs0, hs1;

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycles(2);
        rst = 1'b0;

        $display("[TB] ADD from requester 0");
        applyStimulus(1, 3'b010, 1, 1, 0, 0, 0, 0, 1);
        stepCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycles(5);

        $display("[TB] both requesters continuously valid");
        rst = 1'b1; stepCycles(1); rst = 1'b0;
        applyStimulus(1, 3'b011, 2, 1, 1, 3'b100, 2, 1, 1);
        stepCycles(12);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycles(3);

        $display("[TB] illegal opcode from requester 1");
        applyStimulus(0, 0, 0, 0, 1, 3'b111, 5, 5, 1);
        stepCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycles(4);

        $display("[TB] response backpressure");
        applyStimulus(1, 3'b000, 32'hF0, 32'h0F, 0, 0, 0, 0, 0);
        stepCycles(1);
        applyStimulus(0, 0, 0, 0, 1, 3'b010, 7, 9, 0);
        stepCycles(6);
        rsp_ready = 1'b1;
        waitGrant1(12);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycles(4);

        $display("[TB] reset while a response is pending");
        applyStimulus(1, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        stepCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycles(3);
        rst = 1'b1; stepCycles(1); rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 3'b101, 0, 0, 1);
        stepCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycles(4);

        $display("[TB] counter wrap");
        rst = 1'b1; stepCycles(1); rst = 1'b0;
        applyStimulus(1, 3'b010, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1);
        stepCycles(48);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycles(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (req0_valid && !hs0) begin
                if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
            end else begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_op    = 3'($urandom_range(0, 7));
                req0_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                req0_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            end
            if (req1_valid && !hs1) begin
                if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
            end else begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_op    = 3'($urandom_range(0, 7));
                req1_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                req1_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 249) == 0);
        end

        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycles(10);
        end_req = 1'b1;
        stepCycles(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
